// File: rtl/duty_ramp_if.sv
// Request/status bundle between a duty_ramp controller and its requester.
// master: the requester driving target/step/interval; slave: duty_ramp itself.
interface duty_ramp_if #(
    parameter int DIV_WIDTH = 16
) ();
    logic [7:0]           target;
    logic [7:0]           step;
    logic [DIV_WIDTH-1:0] interval;
    logic                 target_valid;
    logic                 target_ready;
    logic [7:0]           duty_cycle;
    logic                 busy;
    logic                 done;

    modport master (
        output target, step, interval, target_valid,
        input  target_ready, duty_cycle, busy, done
    );

    modport slave (
        input  target, step, interval, target_valid,
        output target_ready, duty_cycle, busy, done
    );
endinterface

// File: rtl/duty_ramp.sv
// duty_ramp: walks an 8-bit duty level toward a requested target in steps of
// 'step', one step every interval+1 clocks, and drives the pwm duty_cycle.
// Optional macro DUTY_RAMP_PERIOD_SYNC_EN: duty_cycle only reloads from the
// internal level when a free-running 8-bit phase counter wraps (phase==8'hFF),
// so the pwm never sees a duty change mid-period. done/busy follow the level.
//
// state | meaning
// IDLE  | waiting for a request, target_ready=1
// RAMP  | stepping level toward target, busy=1
module duty_ramp #(
    parameter int DIV_WIDTH = 16
) (
    input logic        clock,
    input logic        reset,
    duty_ramp_if.slave bus
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t               state;
    logic [7:0]           level;
    logic [7:0]           tgt_q;
    logic [7:0]           step_q;
    logic [DIV_WIDTH-1:0] intv_q;
    logic [DIV_WIDTH-1:0] tick_cnt;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 up;
    logic [8:0]           diff9;
    logic [8:0]           step9;
    logic [8:0]           move9;
    logic [7:0]           next_level;
    logic [7:0]           step_in;
    logic                 accept;

    // Next level after one tick: move by min(step, |target-level|) in 9 bits.
    always_comb begin
        up         = ({1'b0, tgt_q} > {1'b0, level});
        diff9      = up ? ({1'b0, tgt_q} - {1'b0, level})
                        : ({1'b0, level} - {1'b0, tgt_q});
        step9      = {1'b0, step_q};
        move9      = (step9 < diff9) ? step9 : diff9;
        next_level = up ? (level + move9[7:0]) : (level - move9[7:0]);
    end

    assign accept  = bus.target_valid && ready_q;
    assign step_in = (bus.step == 8'd0) ? 8'd1 : bus.step;

    // Request acceptance, tick timing and level stepping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            level    <= 8'd0;
            tgt_q    <= 8'd0;
            step_q   <= 8'd0;
            intv_q   <= '0;
            tick_cnt <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (accept) begin
                        tgt_q    <= bus.target;
                        step_q   <= step_in;
                        intv_q   <= bus.interval;
                        tick_cnt <= '0;
                        if (bus.target == level) begin
                            done_q <= 1'b1;
                        end else begin
                            state   <= RAMP;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (tick_cnt == intv_q) begin
                        tick_cnt <= '0;
                        level    <= next_level;
                        if (next_level == tgt_q) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.target_ready = ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

`ifdef DUTY_RAMP_PERIOD_SYNC_EN
    logic [7:0] phase;
    logic [7:0] duty_q;

    // Reload the pwm duty only at the pwm period wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase  <= 8'd0;
            duty_q <= 8'd0;
        end else begin
            phase <= phase + 8'd1;
            if (phase == 8'hFF) begin
                duty_q <= level;
            end
        end
    end

    assign bus.duty_cycle = duty_q;
`else
    assign bus.duty_cycle = level;
`endif

endmodule
